// File: rtl/disp_ram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | disp_ram_pkg: shared types and sizes for the display RAM arbiter    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package disp_ram_pkg;
    localparam int RAM_DEPTH = 65;
    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_VID  = 2'd1,
        S_WR   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;
endpackage
`default_nettype wire

// File: rtl/disp_wr_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | disp_wr_fifo: small synchronous FIFO buffering game-logic writes    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module disp_wr_fifo
    import disp_ram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    VGA_CLK_IN,
    input  logic    i_rst,
    input  logic    i_push,
    input  wr_req_t i_wdata,
    input  logic    i_pop,
    output wr_req_t o_rdata,
    output logic    o_full,
    output logic    o_empty
);
    localparam int PTR_W = $clog2(DEPTH);

    wr_req_t          r_mem [DEPTH];
    logic [PTR_W:0]   r_wptr;
    logic [PTR_W:0]   r_rptr;
    logic             w_push;
    logic             w_pop;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rptr[PTR_W-1:0]];

    always_ff @(posedge VGA_CLK_IN) begin
        if (w_push) begin
            r_mem[r_wptr[PTR_W-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge VGA_CLK_IN or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/display_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | display_ram_arbiter: shares the character RAM between video reads  |
// | and queued logic writes. Macro ARB_STARVE_GUARD_EN adds write guard |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module display_ram_arbiter
    import disp_ram_pkg::*;
#(
    parameter int WQ_DEPTH = 4
`ifdef ARB_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT = 16
`endif
) (
    input  logic              VGA_CLK_IN,
    input  logic              i_rst,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ready,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              wr_oob,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam logic [ADDR_W-1:0] c_DEPTH_A = ADDR_W'(RAM_DEPTH);

    arb_state_t        r_state;
    arb_state_t        w_next;
    wr_req_t           w_head;
    wr_req_t           w_push_req;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_force;
    logic              w_vid_acc;
    logic              w_vid_oob;
    logic              w_wr_take;
    logic              w_wr_oob;
    logic              r_v1;
    logic              r_oob1;
    logic              r_v2;
    logic              r_oob2;
    logic              r_wr_oob;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;

    assign w_push_req = {wr_addr, wr_data};
    assign wr_ready   = !w_full;
    assign w_wr_take  = wr_valid && !w_full;
    assign w_wr_oob   = w_wr_take && (wr_addr >= c_DEPTH_A);
    assign w_push     = w_wr_take && !w_wr_oob;
    assign w_pop      = (w_next == S_WR);

    assign vid_ready  = !w_force;
    assign w_vid_acc  = vid_req && vid_ready;
    assign w_vid_oob  = (vid_addr >= c_DEPTH_A);

    disp_wr_fifo #(
        .DEPTH (WQ_DEPTH)
    ) u_wr_fifo (
        .VGA_CLK_IN (VGA_CLK_IN),
        .i_rst      (i_rst),
        .i_push     (w_push),
        .i_wdata    (w_push_req),
        .i_pop      (w_pop),
        .o_rdata    (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starve_cnt;

    assign w_force = !w_empty && (r_starve_cnt >= c_LIMIT);

    always_ff @(posedge VGA_CLK_IN or posedge i_rst) begin
        if (i_rst) begin
            r_starve_cnt <= '0;
        end else if (w_empty || (w_next == S_WR)) begin
            r_starve_cnt <= '0;
        end else if (w_next == S_VID) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    assign w_force = 1'b0;
`endif

    always_comb begin
        w_next = S_IDLE;
        if (w_force) begin
            w_next = S_WR;
        end else if (vid_req) begin
            w_next = S_VID;
        end else if (!w_empty) begin
            w_next = S_WR;
        end
    end

    always_ff @(posedge VGA_CLK_IN or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_v1        <= 1'b0;
            r_oob1      <= 1'b0;
            r_v2        <= 1'b0;
            r_oob2      <= 1'b0;
            r_wr_oob    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_WR) begin
                r_ram_addr  <= w_head.addr;
                r_ram_wdata <= w_head.data;
            end else if (w_next == S_VID) begin
                r_ram_addr  <= vid_addr;
            end
            r_v1     <= w_vid_acc;
            r_oob1   <= w_vid_acc && w_vid_oob;
            r_v2     <= r_v1;
            r_oob2   <= r_oob1;
            r_wr_oob <= w_wr_oob;
        end
    end

    // Out-of-range video reads keep their slot but leave the RAM port idle.
    assign ram_en     = (r_state == S_WR) || ((r_state == S_VID) && !r_oob1);
    assign ram_we     = (r_state == S_WR);
    assign ram_addr   = r_ram_addr;
    assign ram_wdata  = r_ram_wdata;
    assign wr_oob     = r_wr_oob;
    assign vid_rvalid = r_v2;
    assign vid_rdata  = (r_v2 && !r_oob2) ? ram_rdata : '0;
endmodule
`default_nettype wire

// File: tb/tb_display_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_display_ram_arbiter: directed scoreboard bench for the arbiter   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_display_ram_arbiter;
    import disp_ram_pkg::*;

    typedef struct { int cyc; logic [7:0] data; } rd_exp_t;
    typedef struct { int cyc; logic [6:0] addr; } ra_exp_t;
    typedef struct { logic [6:0] addr; logic [7:0] data; } wr_exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       vid_req, vid_ready, vid_rvalid;
    logic [6:0] vid_addr;
    logic [7:0] vid_rdata;
    logic       wr_valid, wr_ready, wr_oob;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       ram_en, ram_we;
    logic [6:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int oob_seen = 0;

    rd_exp_t rq[$];
    ra_exp_t aq[$];
    wr_exp_t wq[$];
    int      oq[$];
    int      wcyc[$];

    logic [7:0]   mem [128];
    logic [127:0] wrote = '0;
    logic [7:0]   exp_mem [128];
    logic [127:0] exp_wrote = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    display_ram_arbiter #(.WQ_DEPTH(4)) dut (
        .VGA_CLK_IN (clk),
        .i_rst      (rst),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ready  (vid_ready),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .wr_oob     (wr_oob),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // Character RAM model: unwritten cells read back their own address.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr]   <= ram_wdata;
                wrote[ram_addr] <= 1'b1;
            end else begin
                ram_rdata <= wrote[ram_addr] ? mem[ram_addr] : {1'b0, ram_addr};
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [7:0] d;
        if (vid_req && vid_ready) begin
            if (int'(vid_addr) < RAM_DEPTH) begin
                d = exp_wrote[vid_addr] ? exp_mem[vid_addr] : {1'b0, vid_addr};
                aq.push_back('{cyc + 1, vid_addr});
            end else begin
                d = 8'h00;
            end
            rq.push_back('{cyc + 2, d});
        end
        if (wr_valid && wr_ready) begin
            if (int'(wr_addr) < RAM_DEPTH) wq.push_back('{wr_addr, wr_data});
            else oq.push_back(cyc + 1);
        end
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            chk("rvalid", {31'd0, vid_rvalid}, 32'd1);
            chk("rdata", {24'd0, vid_rdata}, {24'd0, rq[0].data});
            void'(rq.pop_front());
        end else begin
            chk("rvalid_idle", {31'd0, vid_rvalid}, 32'd0);
        end
        if (aq.size() > 0 && aq[0].cyc == cyc) begin
            chk("ram_rd_port", {30'd0, ram_en, ram_we}, 32'd2);
            chk("ram_rd_addr", {25'd0, ram_addr}, {25'd0, aq[0].addr});
            void'(aq.pop_front());
        end else if (ram_en && ram_we && wq.size() > 0) begin
            chk("ram_wr_addr", {25'd0, ram_addr}, {25'd0, wq[0].addr});
            chk("ram_wr_data", {24'd0, ram_wdata}, {24'd0, wq[0].data});
            exp_mem[wq[0].addr]   <= wq[0].data;
            exp_wrote[wq[0].addr] <= 1'b1;
            wcyc.push_back(cyc);
            void'(wq.pop_front());
        end else begin
            chk("ram_idle", {31'd0, ram_en}, 32'd0);
        end
        if (oq.size() > 0 && oq[0] == cyc) begin
            chk("wr_oob", {31'd0, wr_oob}, 32'd1);
            void'(oq.pop_front());
        end else begin
            chk("wr_oob_idle", {31'd0, wr_oob}, 32'd0);
        end
        if (wr_oob) oob_seen++;
`ifndef ARB_STARVE_GUARD_EN
        chk("vid_ready_tied", {31'd0, vid_ready}, 32'd1);
`endif
    end

    initial begin
        int  t0;
        logic got;
        rst = 1'b1; vid_req = 1'b0; vid_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        #2;
        chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_ram_addr", {25'd0, ram_addr}, 32'd0);
        chk("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
        chk("rst_rvalid", {31'd0, vid_rvalid}, 32'd0);
        chk("rst_rdata", {24'd0, vid_rdata}, 32'd0);
        chk("rst_wr_oob", {31'd0, wr_oob}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("post_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("post_rst_vid_ready", {31'd0, vid_ready}, 32'd1);

        // Read-only stream of addresses 0..9.
        for (int i = 0; i < 10; i++) begin
            step(); vid_req = 1'b1; vid_addr = 7'(i);
        end
        step(); vid_req = 1'b0;
        repeat (4) step();

        // Write drain with the video side idle.
        wcyc.delete();
        step(); wr_valid = 1'b1; wr_addr = 7'd5; wr_data = 8'h41; t0 = cyc;
        chk("drain_ready0", {31'd0, wr_ready}, 32'd1);
        step(); wr_addr = 7'd6; wr_data = 8'h42;
        chk("drain_ready1", {31'd0, wr_ready}, 32'd1);
        step(); wr_addr = 7'd7; wr_data = 8'h43;
        chk("drain_ready2", {31'd0, wr_ready}, 32'd1);
        step(); wr_valid = 1'b0;
        chk("drain_ready3", {31'd0, wr_ready}, 32'd1);
        repeat (4) step();
        chk("drain_count", wcyc.size(), 32'd3);
        for (int k = 0; k < wcyc.size() && k < 3; k++)
            chk("drain_cycle", wcyc[k] - t0, 32'(k + 2));

`ifndef ARB_STARVE_GUARD_EN
        // Queue fills while video holds the port continuously.
        wcyc.delete();
        for (int k = 0; k < 4; k++) begin
            step(); vid_req = 1'b1; vid_addr = 7'(k);
            wr_valid = 1'b1; wr_addr = 7'(20 + k); wr_data = 8'(8'h60 + k);
            chk("fill_ready", {31'd0, wr_ready}, 32'd1);
        end
        step(); vid_addr = 7'd4; wr_addr = 7'd24; wr_data = 8'h64;
        chk("full_ready", {31'd0, wr_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(); vid_addr = 7'(5 + k);
            chk("full_hold", {31'd0, wr_ready}, 32'd0);
        end
        step(); vid_req = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            step(); got = wr_ready;
        end
        chk("fifth_accepted", {31'd0, got}, 32'd1);
        step(); wr_valid = 1'b0;
        for (int k = 0; k < 20 && wq.size() > 0; k++) step();
        repeat (2) step();
        chk("full_drain_count", wcyc.size(), 32'd5);
`else
        // One queued write under a continuous video stream.
        wcyc.delete();
        step(); vid_req = 1'b1; vid_addr = 7'd0;
        wr_valid = 1'b1; wr_addr = 7'd30; wr_data = 8'h55; t0 = cyc;
        for (int k = 1; k <= 20; k++) begin
            step(); wr_valid = 1'b0; vid_addr = 7'(k % 10);
            chk("guard_vid_ready", {31'd0, vid_ready}, (k == 17) ? 32'd0 : 32'd1);
        end
        step(); vid_req = 1'b0;
        repeat (4) step();
        chk("guard_wr_count", wcyc.size(), 32'd1);
        if (wcyc.size() > 0) chk("guard_wr_cycle", wcyc[0] - t0, 32'd18);
`endif

        // Out-of-range write and read.
        wcyc.delete();
        oob_seen = 0;
        step(); wr_valid = 1'b1; wr_addr = 7'd70; wr_data = 8'hEE;
        chk("oob_wr_ready", {31'd0, wr_ready}, 32'd1);
        step(); wr_valid = 1'b0; vid_req = 1'b1; vid_addr = 7'd65;
        step(); vid_addr = 7'd5;
        step(); vid_req = 1'b0;
        repeat (4) step();
        chk("oob_pulses", oob_seen, 32'd1);
        chk("oob_no_write", wcyc.size(), 32'd0);

        // Reset with two writes queued and a read in flight.
        step(); vid_req = 1'b1; vid_addr = 7'd3;
        wr_valid = 1'b1; wr_addr = 7'd40; wr_data = 8'hA0;
        step(); wr_addr = 7'd41; wr_data = 8'hA1;
        step(); vid_req = 1'b0; wr_valid = 1'b0;
        #2 rst = 1'b1;
        rq.delete(); aq.delete(); wq.delete(); oq.delete(); wcyc.delete();
        #1;
        chk("arst_ram_en", {31'd0, ram_en}, 32'd0);
        chk("arst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("arst_ram_addr", {25'd0, ram_addr}, 32'd0);
        chk("arst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
        chk("arst_rvalid", {31'd0, vid_rvalid}, 32'd0);
        chk("arst_rdata", {24'd0, vid_rdata}, 32'd0);
        chk("arst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("arst_vid_ready", {31'd0, vid_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) step();
        chk("arst_no_write", wcyc.size(), 32'd0);

        chk("end_rq_empty", rq.size(), 32'd0);
        chk("end_wq_empty", wq.size(), 32'd0);
        chk("end_aq_empty", aq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
